// File: rtl/alu.sv
// Registered 32-bit MiniMicro ALU: logic, add/sub with carry, multiply, shift/rotate,
// extend and compare, with result and NZCV flags captured on the rising clock edge.
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  instruction,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_ANDS = 5'd1;
   localparam logic [4:0] OP_ORRS = 5'd2;
   localparam logic [4:0] OP_MVNS = 5'd3;
   localparam logic [4:0] OP_EORS = 5'd4;
   localparam logic [4:0] OP_ADCS = 5'd5;
   localparam logic [4:0] OP_ADDS = 5'd6;
   localparam logic [4:0] OP_SBCS = 5'd7;
   localparam logic [4:0] OP_SUB  = 5'd8;
   localparam logic [4:0] OP_MULS = 5'd9;
   localparam logic [4:0] OP_LSRS = 5'd10;
   localparam logic [4:0] OP_LSLS = 5'd11;
   localparam logic [4:0] OP_ASR  = 5'd12;
   localparam logic [4:0] OP_ROR  = 5'd13;
   localparam logic [4:0] OP_UXTB = 5'd14;
   localparam logic [4:0] OP_UXTH = 5'd15;
   localparam logic [4:0] OP_SXTB = 5'd16;
   localparam logic [4:0] OP_SXTH = 5'd17;
   localparam logic [4:0] OP_CMP  = 5'd18;

   logic [7:0]  sh;
   logic        is_sub;
   logic        cin;
   logic [31:0] opb;
   logic [32:0] sum;
   logic        ovf;
   logic [31:0] mul_lo;
   logic [32:0] lsl_v;
   logic [32:0] lsr_v;
   logic [32:0] asr_v;
   logic [31:0] ror_v;

   assign sh = num2[7:0];

   // Subtraction is A + ~B + carry-in, so C directly reads as NOT borrow.
   assign is_sub = (instruction == OP_SBCS) || (instruction == OP_SUB) || (instruction == OP_CMP);
   assign opb    = is_sub ? ~num2 : num2;
   always_comb begin
      cin = 1'b0;
      case (instruction)
         OP_ADCS, OP_SBCS: cin = flags[1];
         OP_SUB, OP_CMP:   cin = 1'b1;
         default:          cin = 1'b0;
      endcase
   end
   assign sum    = {1'b0, num1} + {1'b0, opb} + {32'd0, cin};
   assign ovf    = (num1[31] == opb[31]) && (sum[31] != num1[31]);
   assign mul_lo = num1 * num2;

   // Extra guard bit catches the last bit shifted out (valid for 1..32).
   assign lsl_v = {1'b0, num1} << sh;
   assign lsr_v = {num1, 1'b0} >> sh;
   assign asr_v = $signed({num1, 1'b0}) >>> sh;
   assign ror_v = (num1 >> sh[4:0]) | (num1 << (6'd32 - {1'b0, sh[4:0]}));

   logic [31:0] res_n;
   logic [31:0] nz_src;
   logic        upd_nz;
   logic        c_n;
   logic        v_n;

   always_comb begin
      res_n  = result;
      nz_src = result;
      upd_nz = 1'b0;
      c_n    = flags[1];
      v_n    = flags[0];
      case (instruction)
         OP_ANDS: begin res_n = num1 & num2; upd_nz = 1'b1; end
         OP_ORRS: begin res_n = num1 | num2; upd_nz = 1'b1; end
         OP_MVNS: begin res_n = ~num1;       upd_nz = 1'b1; end
         OP_EORS: begin res_n = num1 ^ num2; upd_nz = 1'b1; end
         OP_MULS: begin res_n = mul_lo;      upd_nz = 1'b1; end
         OP_ADCS, OP_ADDS, OP_SBCS, OP_SUB: begin
            res_n  = sum[31:0];
            upd_nz = 1'b1;
            c_n    = sum[32];
            v_n    = ovf;
         end
         OP_CMP: begin
            nz_src = sum[31:0];
            c_n    = sum[32];
            v_n    = ovf;
         end
         OP_LSLS: begin
            upd_nz = 1'b1;
            if (sh == 8'd0) res_n = num1;
            else if (sh <= 8'd32) begin res_n = lsl_v[31:0]; c_n = lsl_v[32]; end
            else begin res_n = 32'd0; c_n = 1'b0; end
         end
         OP_LSRS: begin
            upd_nz = 1'b1;
            if (sh == 8'd0) res_n = num1;
            else if (sh <= 8'd32) begin res_n = lsr_v[32:1]; c_n = lsr_v[0]; end
            else begin res_n = 32'd0; c_n = 1'b0; end
         end
         OP_ASR: begin
            upd_nz = 1'b1;
            if (sh == 8'd0) res_n = num1;
            else if (sh < 8'd32) begin res_n = asr_v[32:1]; c_n = asr_v[0]; end
            else begin res_n = {32{num1[31]}}; c_n = num1[31]; end
         end
         OP_ROR: begin
            upd_nz = 1'b1;
            res_n  = ror_v;
            if (sh != 8'd0) c_n = ror_v[31];
         end
         OP_UXTB: res_n = {24'd0, num1[7:0]};
         OP_UXTH: res_n = {16'd0, num1[15:0]};
         OP_SXTB: res_n = {{24{num1[7]}}, num1[7:0]};
         OP_SXTH: res_n = {{16{num1[15]}}, num1[15:0]};
         default: res_n = result;
      endcase
      if (upd_nz) nz_src = res_n;
   end

   logic n_n;
   logic z_n;
   assign n_n = (upd_nz || instruction == OP_CMP) ? nz_src[31] : flags[3];
   assign z_n = (upd_nz || instruction == OP_CMP) ? (nz_src == 32'd0) : flags[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= 32'd0;
         flags  <= 4'b0000;
      end else begin
         result <= res_n;
         flags  <= {n_n, z_n, c_n, v_n};
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, shift boundaries, random ops against
// an arithmetic reference model, and asynchronous reset mid-stream.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [4:0]  instruction;
   logic [31:0] num1;
   logic [31:0] num2;
   logic [31:0] result;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_res;
   logic [3:0]  m_flags;
   logic [35:0] exp_q[$];

   alu dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction),
      .num1(num1), .num2(num2), .result(result), .flags(flags)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: plain wide-integer arithmetic on the operation definitions.
   function automatic logic [35:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pr,
                                           input logic [3:0] pf);
      logic [31:0] r;
      logic [31:0] fsrc;
      logic n, z, c, v, upd;
      longint sa, sb, t;
      longint unsigned ua, ub, u, bin;
      int s;
      r = pr;
      {n, z, c, v} = pf;
      upd = 1'b0;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = $signed(a);
      sb = $signed(b);
      s = int'(b[7:0]);
      case (op)
         5'd1: begin r = a & b; upd = 1'b1; end
         5'd2: begin r = a | b; upd = 1'b1; end
         5'd3: begin r = ~a;    upd = 1'b1; end
         5'd4: begin r = a ^ b; upd = 1'b1; end
         5'd5, 5'd6: begin
            bin = (op == 5'd5) ? {63'd0, c} : 64'd0;
            u = ua + ub + bin;
            r = u[31:0];
            t = sa + sb + longint'(bin);
            c = u[32];
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            upd = 1'b1;
         end
         5'd7, 5'd8, 5'd18: begin
            bin = (op == 5'd7) ? {63'd0, ~c} : 64'd0;
            u = ua - ub - bin;
            t = sa - sb - longint'(bin);
            c = (ua >= ub + bin);
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            if (op == 5'd18) begin
               n = u[31];
               z = (u[31:0] == 32'd0);
            end else begin
               r = u[31:0];
               upd = 1'b1;
            end
         end
         5'd9: begin u = ua * ub; r = u[31:0]; upd = 1'b1; end
         5'd10, 5'd11: begin
            upd = 1'b1;
            if (s == 0) r = a;
            else if (s > 32) begin r = 32'd0; c = 1'b0; end
            else if (op == 5'd11) begin u = ua << s; r = u[31:0]; c = u[32]; end
            else begin u = ua >> s; r = u[31:0]; u = ua >> (s - 1); c = u[0]; end
         end
         5'd12: begin
            upd = 1'b1;
            if (s == 0) r = a;
            else if (s >= 32) begin r = {32{a[31]}}; c = a[31]; end
            else begin t = sa >>> s; r = t[31:0]; t = sa >>> (s - 1); c = t[0]; end
         end
         5'd13: begin
            upd = 1'b1;
            r = a;
            for (int i = 0; i < s % 32; i++) r = {r[0], r[31:1]};
            if (s != 0) c = r[31];
         end
         5'd14: r = a & 32'h0000_00FF;
         5'd15: r = a & 32'h0000_FFFF;
         5'd16: r = (a[7] ? 32'hFFFF_FF00 : 32'd0) | (a & 32'hFF);
         5'd17: r = (a[15] ? 32'hFFFF_0000 : 32'd0) | (a & 32'hFFFF);
         default: r = pr;
      endcase
      if (upd) begin
         fsrc = r;
         n = fsrc[31];
         z = (fsrc == 32'd0);
      end
      return {n, z, c, v, r};
   endfunction

   // driver: apply one op, then compare result and flags one edge later
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [35:0] e;
      @(negedge clk);
      instruction = op;
      num1 = a;
      num2 = b;
      e = ref_alu(op, a, b, m_res, m_flags);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      m_res = e[31:0];
      m_flags = e[35:32];
      check($sformatf("op%0d_res", op), result, e[31:0]);
      check($sformatf("op%0d_flags", op), {28'd0, flags}, {28'd0, e[35:32]});
   endtask

   initial begin
      rst_n = 1'b0;
      instruction = 5'd0;
      num1 = 32'd0;
      num2 = 32'd0;
      m_res = 32'd0;
      m_flags = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_res", result, 32'd0);
      check("reset_flags", {28'd0, flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(5'd1, 32'd15, 32'd10);          check("ands", result, 32'd10);
      check("ands_flags", {28'd0, flags}, 32'd0);
      do_op(5'd2, 32'd500, 32'd5);          check("orrs", result, 32'd501);
      do_op(5'd3, 32'hFFFFFFA0, 32'd0);     check("mvns", result, 32'h5F);
      do_op(5'd4, 32'd295, 32'd426);        check("eors", result, 32'd141);
      do_op(5'd6, 32'd51526, 32'hFFFFFFA0); check("adds", result, 32'd51430);
      check("adds_flags", {28'd0, flags}, 32'b0010);
      do_op(5'd5, 32'd9, 32'd1);            check("adcs", result, 32'd11);
      do_op(5'd8, 32'd16, 32'd4);           check("sub", result, 32'd12);
      check("sub_c", {31'd0, flags[1]}, 32'd1);
      do_op(5'd7, 32'd50, 32'd4);           check("sbcs", result, 32'd46);
      do_op(5'd18, 32'd22, 32'd32);         check("cmp_res", result, 32'd46);
      check("cmp_flags", {28'd0, flags}, 32'b1000);
      do_op(5'd6, 32'h7FFFFFFF, 32'd1);     check("adds_ovf", result, 32'h80000000);
      check("adds_ovf_flags", {28'd0, flags}, 32'b1001);
      do_op(5'd9, 32'd5, 32'd4);            check("muls", result, 32'd20);
      do_op(5'd11, 32'd13, 32'd3);          check("lsls", result, 32'd104);
      do_op(5'd10, 32'd13, 32'd3);          check("lsrs", result, 32'd1);
      check("lsrs_c", {31'd0, flags[1]}, 32'd1);
      do_op(5'd12, 32'd205, 32'd3);         check("asr", result, 32'd25);
      do_op(5'd12, 32'h80000000, 32'd4);    check("asr_neg", result, 32'hF8000000);
      check("asr_neg_n", {31'd0, flags[3]}, 32'd1);
      do_op(5'd13, 32'd595, 32'd5);         check("ror", result, 32'h98000012);
      check("ror_c", {31'd0, flags[1]}, 32'd1);
      do_op(5'd14, 32'd490, 32'd0);         check("uxtb", result, 32'd234);
      do_op(5'd15, 32'd56623, 32'd0);       check("uxth", result, 32'd56623);
      do_op(5'd16, 32'h5ACC15, 32'd0);      check("sxtb", result, 32'd21);
      do_op(5'd17, 32'h5ACC15, 32'd0);      check("sxth", result, 32'hFFFFCC15);

      // shift-amount boundaries and hold opcodes
      do_op(5'd11, 32'h80000001, 32'd0);
      do_op(5'd11, 32'h80000001, 32'd32);   check("lsl32_c", {31'd0, flags[1]}, 32'd1);
      do_op(5'd11, 32'hFFFFFFFF, 32'd33);   check("lsl33", result, 32'd0);
      do_op(5'd10, 32'h80000000, 32'd32);
      do_op(5'd10, 32'hFFFFFFFF, 32'h1FF);
      do_op(5'd12, 32'h80000000, 32'd200);  check("asr200", result, 32'hFFFFFFFF);
      do_op(5'd13, 32'h80000000, 32'd32);
      do_op(5'd13, 32'h00000001, 32'd0);
      do_op(5'd0, 32'h12345678, 32'd1);
      do_op(5'd25, 32'h12345678, 32'd1);
      do_op(5'd31, 32'h0, 32'd0);

      // random stream, including carry chains and small shift amounts
      for (int i = 0; i < 400; i++) begin
         logic [31:0] b;
         b = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
         do_op(5'($urandom_range(0, 31)), $urandom, b);
      end

      // asynchronous reset between edges
      do_op(5'd6, 32'h7FFFFFFF, 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_res", result, 32'd0);
      check("async_rst_flags", {28'd0, flags}, 32'd0);
      m_res = 32'd0;
      m_flags = 4'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_op(5'd0, 32'hDEADBEEF, 32'd7);     check("nop_after_rst", result, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
